// File: rtl/op_dispatch_queue_if.sv
// FHE op type shared with the cpu, plus the dispatch-queue port bundle.
// Host side uses master, the queue uses slave.
package op_dispatch_pkg;

  typedef enum logic [1:0] {
    NO_OP     = 2'd0,
    CT_CT_ADD = 2'd1,
    CT_PT_ADD = 2'd2,
    CT_PT_MUL = 2'd3
  } op_mode_t;

  typedef struct packed {
    op_mode_t   mode;
    logic [3:0] idx1_a;
    logic [3:0] idx1_b;
    logic [3:0] idx2_a;
    logic [3:0] idx2_b;
    logic [3:0] out_a;
    logic [3:0] out_b;
  } operation;

endpackage

interface op_dispatch_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
);
  import op_dispatch_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  operation                   in_op;
  operation                   op;
  logic                       done_in;
  logic                       busy;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic [CNT_W-1:0]           retired_count;
  logic                       timeout_err;

  modport master (
    output in_valid, in_op, done_in,
    input  in_ready, op, busy,
    input  fifo_count, retired_count,
    input  timeout_err
  );

  modport slave (
    input  in_valid, in_op, done_in,
    output in_ready, op, busy,
    output fifo_count, retired_count,
    output timeout_err
  );

endinterface

// File: rtl/op_dispatch_queue.sv
// FIFO-buffered, one-at-a-time issue stage in front of the FHE cpu.
// Optional WAIT watchdog: define OP_DISPATCH_TIMEOUT_EN.
module op_dispatch_queue
  import op_dispatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
`ifdef OP_DISPATCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 500
`endif
) (
  input  logic          clk,
  input  logic          reset,
  op_dispatch_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    SETTLE
  } state_t;

  operation         mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  state_t           state;
  operation         op_q;
  logic [CNT_W-1:0] retired_q;
  operation         head;
  logic             push;
  logic             pop;

  assign head         = mem[rd_ptr];
  assign bus.in_ready = (count < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == IDLE) && (count != '0);

  assign bus.op            = op_q;
  assign bus.fifo_count    = count;
  assign bus.retired_count = retired_q;
  assign bus.busy          = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_op;
    end
  end

  // Pointer width equals log2(DEPTH), so wrap is free.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef OP_DISPATCH_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timeout_q;
  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      retired_q <= '0;
`ifdef OP_DISPATCH_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          // NO_OP entries are dropped here and never reach the cpu.
          if (pop && head.mode != NO_OP) begin
            op_q  <= head;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          op_q  <= '0;
          state <= WAIT;
`ifdef OP_DISPATCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (bus.done_in) begin
            retired_q <= retired_q + 1'b1;
            state     <= SETTLE;
          end
`ifdef OP_DISPATCH_TIMEOUT_EN
          else if (wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
            timeout_q <= 1'b1;
            state     <= SETTLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        SETTLE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
